// File: rtl/vertex_averager.sv
// vertex_averager: signed per-channel mean of COUNT packed vertex words.
// Define VERTEX_AVERAGER_ROUND_NEAREST_EN for round-half-away-from-zero.
module vertex_averager #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 3,
  parameter int FIELD_W  = 10,
  parameter int MAX_PTS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        src_base,
  input  logic [$clog2(MAX_PTS):0] count,
  input  logic [ADDR_W-1:0]        dst_addr,
  output logic                     src_en,
  output logic [ADDR_W-1:0]        src_a,
  input  logic [DATA_W-1:0]        src_do,
  output logic                     dst_en,
  output logic [DATA_W/8-1:0]      dst_we,
  output logic [ADDR_W-1:0]        dst_a,
  output logic [DATA_W-1:0]        dst_di,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CNT_W = $clog2(MAX_PTS) + 1;
  localparam int ACC_W = FIELD_W + $clog2(MAX_PTS) + 1;
  localparam int REM_W = CNT_W;
  localparam int DC_W  = $clog2(ACC_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DIV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [DC_W-1:0]   dcnt_q, dcnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic              err_q, err_d;

  logic [CHANNELS-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [CHANNELS-1:0][ACC_W-1:0] quo_q, quo_d;
  logic [CHANNELS-1:0][REM_W-1:0] rem_q, rem_d;
  logic [CHANNELS-1:0]            neg_q, neg_d;

  logic [CHANNELS-1:0][FIELD_W-1:0] fld;
  logic [CHANNELS-1:0][ACC_W-1:0]   acc_sum;
  logic [CHANNELS-1:0][ACC_W-1:0]   mag;
  logic [CHANNELS-1:0]              sgn;
  logic [CHANNELS-1:0][REM_W-1:0]   rem_sh;
  logic [CHANNELS-1:0][REM_W-1:0]   rem_nx;
  logic [CHANNELS-1:0][ACC_W-1:0]   quo_nx;
  logic [CHANNELS-1:0][FIELD_W-1:0] res;
  logic [DATA_W-1:0]                pack;

  logic cnt_ok;
  logic unused_ok;

  assign cnt_ok = (count != '0) && (count <= CNT_W'(MAX_PTS));
  assign unused_ok = ^{src_do, rem_q};

  // Per-channel datapath: accumulate, take magnitude, one restoring step.
  always_comb begin
    fld     = '0;
    acc_sum = acc_q;
    mag     = '0;
    sgn     = '0;
    rem_sh  = '0;
    rem_nx  = '0;
    quo_nx  = '0;
    res     = '0;
    pack    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      fld[c] = src_do[c*FIELD_W +: FIELD_W];
      if (rd_vld_q) begin
        acc_sum[c] = acc_q[c] +
          {{(ACC_W-FIELD_W){fld[c][FIELD_W-1]}}, fld[c]};
      end
      sgn[c] = acc_sum[c][ACC_W-1];
      mag[c] = sgn[c] ? (~acc_sum[c] + ACC_W'(1)) : acc_sum[c];
`ifdef VERTEX_AVERAGER_ROUND_NEAREST_EN
      mag[c] = mag[c] + ACC_W'(cnt_q >> 1);
`endif
      rem_sh[c] = {rem_q[c][REM_W-2:0], quo_q[c][ACC_W-1]};
      if (rem_sh[c] >= cnt_q) begin
        rem_nx[c] = rem_sh[c] - cnt_q;
        quo_nx[c] = {quo_q[c][ACC_W-2:0], 1'b1};
      end else begin
        rem_nx[c] = rem_sh[c];
        quo_nx[c] = {quo_q[c][ACC_W-2:0], 1'b0};
      end
      res[c] = neg_q[c] ? (~quo_q[c][FIELD_W-1:0] + FIELD_W'(1))
                        : quo_q[c][FIELD_W-1:0];
      pack[c*FIELD_W +: FIELD_W] = res[c];
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dcnt_d   = dcnt_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    rd_vld_d = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && cnt_ok) begin
          base_d  = src_base;
          dst_d   = dst_addr;
          cnt_d   = count;
          idx_d   = '0;
          acc_d   = '0;
          state_d = S_READ;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      S_READ: begin
        rd_vld_d = 1'b1;
        acc_d    = acc_sum;
        idx_d    = idx_q + CNT_W'(1);
        if (idx_q == cnt_q - CNT_W'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Last word lands here; divider is seeded with the magnitude.
        acc_d   = acc_sum;
        quo_d   = mag;
        neg_d   = sgn;
        rem_d   = '0;
        dcnt_d  = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        quo_d  = quo_nx;
        rem_d  = rem_nx;
        dcnt_d = dcnt_q + DC_W'(1);
        if (dcnt_q == DC_W'(ACC_W - 1)) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      dcnt_q   <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      neg_q    <= '0;
      rd_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dcnt_q   <= dcnt_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      rd_vld_q <= rd_vld_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    src_en = 1'b0;
    src_a  = '0;
    dst_en = 1'b0;
    dst_we = '0;
    dst_a  = '0;
    dst_di = '0;
    busy   = 1'b0;
    done   = 1'b0;
    err    = err_q;
    unique case (state_q)
      S_READ: begin
        busy   = 1'b1;
        src_en = 1'b1;
        src_a  = base_q + ADDR_W'(idx_q);
      end
      S_DRAIN: busy = 1'b1;
      S_DIV:   busy = 1'b1;
      S_WRITE: begin
        busy   = 1'b1;
        dst_en = 1'b1;
        dst_we = '1;
        dst_a  = dst_q;
        dst_di = pack;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vertex_averager.sv
// tb_vertex_averager: scoreboard bench with a shared source/destination RAM.
// Expected words come from a behavioural mean model or fixed test values.
module tb_vertex_averager;

  localparam int ACC_W = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  src_base = '0;
  logic [3:0]  count = '0;
  logic [8:0]  dst_addr = '0;
  logic        src_en;
  logic [8:0]  src_a;
  logic [31:0] src_do;
  logic        dst_en;
  logic [3:0]  dst_we;
  logic [8:0]  dst_a;
  logic [31:0] dst_di;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] mem [0:511];
  logic        pl_we = 1'b0;
  logic [8:0]  pl_a = '0;
  logic [31:0] pl_d = '0;

  int pass_cnt = 0;
  int tot_cnt = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  int src_cnt = 0;
  int ovl_cnt = 0;

  logic [31:0] exp_q[$];
  logic [8:0]  expa_q[$];
  logic [8:0]  rd_q[$];
  int          rdk_q[$];

  int          done_k;
  int          write_k;
  logic [31:0] wdata;
  logic [8:0]  waddr;
  logic [3:0]  wwe;
  logic        busy_at_done;

  vertex_averager dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_base (src_base),
    .count    (count),
    .dst_addr (dst_addr),
    .src_en   (src_en),
    .src_a    (src_a),
    .src_do   (src_do),
    .dst_en   (dst_en),
    .dst_we   (dst_we),
    .dst_a    (dst_a),
    .dst_di   (dst_di),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (src_en) src_do <= mem[src_a];
    if (dst_en && (&dst_we)) mem[dst_a] <= dst_di;
    if (pl_we) mem[pl_a] <= pl_d;
  end

  always @(negedge clk) begin
    if (src_en && dst_en) ovl_cnt <= ovl_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (dst_en) wr_cnt <= wr_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (src_en) src_cnt <= src_cnt + 1;
  end

  function automatic logic [31:0] pk(input int x, input int y, input int z);
    logic [9:0] fx, fy, fz;
    fx = 10'(x);
    fy = 10'(y);
    fz = 10'(z);
    return {2'b00, fz, fy, fx};
  endfunction

  function automatic logic [31:0] model(input logic [8:0] b, input int n);
    logic [31:0] r;
    logic [31:0] w;
    logic signed [9:0] f;
    int s, q;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      s = 0;
      for (int i = 0; i < n; i++) begin
        w = mem[(int'(b) + i) % 512];
        f = w[c*10 +: 10];
        s = s + int'(f);
      end
      q = (s < 0) ? -s : s;
`ifdef VERTEX_AVERAGER_ROUND_NEAREST_EN
      q = q + n / 2;
`endif
      q = q / n;
      if (s < 0) q = -q;
      r[c*10 +: 10] = q[9:0];
    end
    return r;
  endfunction

  task automatic poke(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic run_job(input logic [8:0] b, input logic [3:0] n,
                         input logic [8:0] d);
    done_k = -1;
    write_k = -1;
    wdata = 'x;
    waddr = 'x;
    wwe = 'x;
    busy_at_done = 1'bx;
    rd_q.delete();
    rdk_q.delete();
    @(negedge clk);
    src_base = b;
    count = n;
    dst_addr = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (src_en) begin
        rd_q.push_back(src_a);
        rdk_q.push_back(k);
      end
      if (dst_en) begin
        write_k = k;
        wdata = dst_di;
        waddr = dst_a;
        wwe = dst_we;
      end
      if (done) begin
        done_k = k;
        busy_at_done = busy;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    tot_cnt++;
    if ({busy, done, err, src_en, dst_en} !== 5'b0)
      $display("FAIL reset_ctl: got %b want 00000",
               {busy, done, err, src_en, dst_en});
    else pass_cnt++;
    tot_cnt++;
    if ({src_a, dst_a, dst_di, dst_we} !== '0)
      $display("FAIL reset_bus: got %h want 0",
               {src_a, dst_a, dst_di, dst_we});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] e;
    logic [8:0]  ea;
    poke(9'h010, pk(10, 0, 0));
    poke(9'h011, pk(20, 0, 0));
    poke(9'h012, pk(30, 0, 0));
    poke(9'h013, pk(40, 0, 0));
    exp_q.push_back(pk(25, 0, 0));
    expa_q.push_back(9'h100);
    run_job(9'h010, 4'd4, 9'h100);
    e = exp_q.pop_front();
    ea = expa_q.pop_front();
    tot_cnt++;
    if (wdata !== e) $display("FAIL basic_data: got %h want %h", wdata, e);
    else pass_cnt++;
    tot_cnt++;
    if (waddr !== ea) $display("FAIL basic_addr: got %h want %h", waddr, ea);
    else pass_cnt++;
    tot_cnt++;
    if (wwe !== 4'hF) $display("FAIL basic_we: got %h want f", wwe);
    else pass_cnt++;
    tot_cnt++;
    if (done_k != 4 + 3 + ACC_W)
      $display("FAIL basic_latency: got %0d want %0d", done_k, 4 + 3 + ACC_W);
    else pass_cnt++;
    tot_cnt++;
    if (write_k != 4 + 2 + ACC_W)
      $display("FAIL basic_write_cyc: got %0d want %0d",
               write_k, 4 + 2 + ACC_W);
    else pass_cnt++;
    tot_cnt++;
    if (busy_at_done !== 1'b0)
      $display("FAIL basic_busy_done: got %b want 0", busy_at_done);
    else pass_cnt++;
    tot_cnt++;
    if (rd_q.size() != 4)
      $display("FAIL basic_nreads: got %0d want 4", rd_q.size());
    else pass_cnt++;
    tot_cnt++;
    if (mem[9'h100] !== e)
      $display("FAIL basic_mem: got %h want %h", mem[9'h100], e);
    else pass_cnt++;
  endtask

  task automatic test_signed;
    logic [31:0] e;
    poke(9'h020, pk(0, -1, 0));
    poke(9'h021, pk(0, -2, 0));
    poke(9'h022, pk(0, -3, 0));
    poke(9'h023, pk(0, -4, 0));
`ifdef VERTEX_AVERAGER_ROUND_NEAREST_EN
    exp_q.push_back(pk(0, -3, 0));
`else
    exp_q.push_back(pk(0, -2, 0));
`endif
    run_job(9'h020, 4'd4, 9'h101);
    e = exp_q.pop_front();
    tot_cnt++;
    if (wdata !== e) $display("FAIL signed_data: got %h want %h", wdata, e);
    else pass_cnt++;
  endtask

  task automatic test_nonpow2;
    logic [31:0] e;
    poke(9'h030, pk(7, 0, 0));
    poke(9'h031, pk(8, 0, 0));
    poke(9'h032, pk(10, 0, 0));
    exp_q.push_back(pk(8, 0, 0));
    run_job(9'h030, 4'd3, 9'h104);
    e = exp_q.pop_front();
    tot_cnt++;
    if (wdata !== e) $display("FAIL np2_a: got %h want %h", wdata, e);
    else pass_cnt++;
    poke(9'h038, pk(1, 0, 0));
    poke(9'h039, pk(1, 0, 0));
    poke(9'h03A, pk(2, 0, 0));
    exp_q.push_back(pk(1, 0, 0));
    run_job(9'h038, 4'd3, 9'h038);
    e = exp_q.pop_front();
    tot_cnt++;
    if (wdata !== e) $display("FAIL np2_b: got %h want %h", wdata, e);
    else pass_cnt++;
    tot_cnt++;
    if (mem[9'h038] !== e)
      $display("FAIL np2_inplace: got %h want %h", mem[9'h038], e);
    else pass_cnt++;
    for (int i = 0; i < 8; i++)
      poke(9'(9'h040 + i), pk(511, -512, (i * 97) % 300 - 150));
    exp_q.push_back(model(9'h040, 8));
    run_job(9'h040, 4'd8, 9'h10A);
    e = exp_q.pop_front();
    tot_cnt++;
    if (wdata !== e) $display("FAIL fullscale: got %h want %h", wdata, e);
    else pass_cnt++;
    tot_cnt++;
    if (done_k != 8 + 3 + ACC_W)
      $display("FAIL fullscale_lat: got %0d want %0d", done_k, 8 + 3 + ACC_W);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    logic [31:0] e;
    logic [8:0] want [4];
    want = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
    poke(9'h1FE, pk(100, 5, -7));
    poke(9'h1FF, pk(-100, 6, 0));
    poke(9'h000, pk(3, 7, 0));
    poke(9'h001, pk(5, 8, 0));
    exp_q.push_back(model(9'h1FE, 4));
    run_job(9'h1FE, 4'd4, 9'h105);
    e = exp_q.pop_front();
    tot_cnt++;
    if (wdata !== e) $display("FAIL wrap_data: got %h want %h", wdata, e);
    else pass_cnt++;
    tot_cnt++;
    if (rd_q.size() != 4) begin
      $display("FAIL wrap_nreads: got %0d want 4", rd_q.size());
    end else begin
      pass_cnt++;
      for (int i = 0; i < 4; i++) begin
        tot_cnt++;
        if (rd_q[i] !== want[i] || rdk_q[i] != i + 1)
          $display("FAIL wrap_rd%0d: got %h@%0d want %h@%0d",
                   i, rd_q[i], rdk_q[i], want[i], i + 1);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_illegal;
    int e0, b0, s0, w0;
    logic [3:0] bad [2];
    bad = '{4'd0, 4'd9};
    @(negedge clk);
    #1;
    e0 = err_cnt;
    b0 = busy_cnt;
    s0 = src_cnt;
    w0 = wr_cnt;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      count = bad[j];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tot_cnt++;
      if (err !== 1'b1) $display("FAIL illegal_err%0d: got %b want 1", j, err);
      else pass_cnt++;
      @(negedge clk);
      tot_cnt++;
      if (err !== 1'b0)
        $display("FAIL illegal_pulse%0d: got %b want 0", j, err);
      else pass_cnt++;
    end
    @(negedge clk);
    #1;
    tot_cnt++;
    if (err_cnt - e0 != 2)
      $display("FAIL illegal_count: got %0d want 2", err_cnt - e0);
    else pass_cnt++;
    tot_cnt++;
    if ((busy_cnt - b0) + (src_cnt - s0) + (wr_cnt - w0) != 0)
      $display("FAIL illegal_quiet: got %0d want 0",
               (busy_cnt - b0) + (src_cnt - s0) + (wr_cnt - w0));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int w0, d0;
    poke(9'h050, pk(9, 9, 9));
    poke(9'h051, pk(9, 9, 9));
    poke(9'h052, pk(9, 9, 9));
    poke(9'h053, pk(9, 9, 9));
    @(negedge clk);
    #1;
    w0 = wr_cnt;
    d0 = done_cnt;
    @(negedge clk);
    src_base = 9'h050;
    count = 4'd4;
    dst_addr = 9'h107;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    tot_cnt++;
    if (busy !== 1'b1) $display("FAIL rstmid_busy_pre: got %b want 1", busy);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    tot_cnt++;
    if ({busy, done, err, src_en, dst_en} !== 5'b0)
      $display("FAIL rstmid_ctl: got %b want 00000",
               {busy, done, err, src_en, dst_en});
    else pass_cnt++;
    tot_cnt++;
    if ({src_a, dst_a, dst_di, dst_we} !== '0)
      $display("FAIL rstmid_bus: got %h want 0",
               {src_a, dst_a, dst_di, dst_we});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    tot_cnt++;
    if (wr_cnt != w0 || done_cnt != d0)
      $display("FAIL rstmid_nowrite: got wr %0d done %0d want 0 0",
               wr_cnt - w0, done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy;
    int w0, d0;
    logic [31:0] e;
    poke(9'h150, 32'h0000_0000);
    poke(9'h060, pk(4, -4, 1));
    poke(9'h061, pk(4, -4, 1));
    poke(9'h062, pk(4, -4, 1));
    poke(9'h063, pk(4, -4, 1));
    @(negedge clk);
    #1;
    w0 = wr_cnt;
    d0 = done_cnt;
    exp_q.push_back(pk(4, -4, 1));
    done_k = -1;
    wdata = 'x;
    @(negedge clk);
    src_base = 9'h060;
    count = 4'd4;
    dst_addr = 9'h106;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (k == 5) begin
        src_base = 9'h010;
        count = 4'd2;
        dst_addr = 9'h150;
        start = 1'b1;
      end
      if (k == 6) start = 1'b0;
      if (dst_en) wdata = dst_di;
      if (done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    e = exp_q.pop_front();
    tot_cnt++;
    if (wdata !== e) $display("FAIL busy_start_data: got %h want %h", wdata, e);
    else pass_cnt++;
    tot_cnt++;
    if (done_k != 4 + 3 + ACC_W)
      $display("FAIL busy_start_lat: got %0d want %0d", done_k, 4 + 3 + ACC_W);
    else pass_cnt++;
    repeat (40) @(negedge clk);
    #1;
    tot_cnt++;
    if (done_cnt - d0 != 1 || wr_cnt - w0 != 1)
      $display("FAIL busy_start_once: got done %0d wr %0d want 1 1",
               done_cnt - d0, wr_cnt - w0);
    else pass_cnt++;
    tot_cnt++;
    if (mem[9'h150] !== 32'h0)
      $display("FAIL busy_start_ignored: got %h want 0", mem[9'h150]);
    else pass_cnt++;
  endtask

  task automatic test_no_overlap;
    tot_cnt++;
    if (ovl_cnt != 0 || exp_q.size() != 0)
      $display("FAIL overlap_sb: got ovl %0d left %0d want 0 0",
               ovl_cnt, exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_nonpow2();
    test_wrap();
    test_illegal();
    test_reset_mid();
    test_start_while_busy();
    test_no_overlap();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
